hes_stream_decryptor: RTL and testbench
=======================================

Name: hes_stream_decryptor

Overview:
- Receive-side endpoint of the HES byte-stream cipher link.
- Accepts framed ciphertext on a ready/valid byte stream: header byte (IV), length byte, N ciphertext bytes, optional checksum trailer.
- Regenerates the keystream from the static key and the IV, XOR-decrypts the payload, and emits plaintext with a last flag.
- Reports per-frame completion and error status to the link controller.

Parameters:
- MAX_LEN, 255: largest accepted payload length in bytes (1..255). A length byte above MAX_LEN is a framing error.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- key  input  8  static link key; must be stable during a frame.
- in_valid  input  1  ciphertext byte valid.
- in_data  input  8  framed ciphertext byte.
- in_ready  output  1  decryptor can accept in_data.
- out_valid  output  1  plaintext byte valid.
- out_data  output  8  plaintext byte.
- out_last  output  1  qualifies out_valid; marks the final payload byte of the frame.
- out_ready  input  1  downstream accepts out_data.
- frame_done  output  1  one-cycle pulse when a frame ends, normally or by error.
- frame_err  output  1  valid with frame_done: 1 = length error or checksum mismatch.

Behaviour:
- Reset (async, reset_n=0): state=HDR; in_ready=0 while reset_n=0, then 1 in HDR; out_valid=0, out_data=0, out_last=0, frame_done=0, frame_err=0; seed, counter and checksum cleared.
- Input accept: in_valid & in_ready. out_data/out_last are held stable while out_valid & !out_ready.
- in_ready by state:
  - HDR, LEN, CHK: 1.
  - PAY: !out_valid | out_ready. This is a single output register with no bubble at full throughput.
- FSM:
  - HDR: on accept, seed <= key ^ in_data, checksum <= 0, then go to LEN.
  - LEN: on accept, remaining <= in_data and counter <= seed.
    - If in_data == 0: go to CHK, or to HDR with frame_done=1/frame_err=0 when checking is compiled out.
    - If in_data > MAX_LEN: frame_done=1, frame_err=1, go to HDR. The frame is dropped and the next byte is treated as a header.
    - Otherwise go to PAY.
  - PAY: on accept:
    - out_data <= in_data ^ INV_SBOX[counter]; out_valid <= 1.
    - counter <= counter + 1, 8-bit wrap (0xFF to 0x00).
    - checksum <= checksum ^ plaintext; remaining decrements.
    - When remaining == 1: out_last <= 1, go to CHK (or HDR with a frame_done pulse when checking is compiled out).
  - CHK: on accept, frame_done=1, frame_err = (in_data != checksum), go to HDR.
- Latency: plaintext is registered; out_valid rises the cycle after the payload byte is accepted.
- frame_done/frame_err are registered, asserting the cycle after the terminating accept. frame_err is 0 whenever frame_done=0.
- Header and length bytes are accepted in CHK/HDR even while the last payload byte is still held in the output register. The output register drains independently.
- INV_SBOX is the standard FIPS-197 AES inverse S-box; byte i of the payload uses INV_SBOX[(seed + i) mod 256].
- Reset mid-frame: the frame is discarded with no frame_done pulse; the FSM restarts at HDR.

Optional Feature:
- HES_DEC_CHECK_EN defined:
  - A trailer byte follows the payload; the trailer equals the XOR of all plaintext bytes (0x00 for an empty frame).
  - The CHK state exists, and a mismatch sets frame_err.
- HES_DEC_CHECK_EN undefined:
  - No trailer and no CHK state; the checksum register is removed.
  - frame_done pulses after the last payload byte (or after LEN for an empty frame).
  - frame_err flags length errors only.

Decomposition:
- hes_pkg holds:
  - the INV_SBOX constant array [0:255] of 8-bit values;
  - the dec_state_t enum {HDR, LEN, PAY, CHK};
  - a localparam for the byte width of 8.
- Sub-module hes_inv_sbox: combinational 8-to-8 lookup indexed by counter. The same sub-module is reusable by the transmit side.

Test Plan:
- Basic frame, key=0x00, in: 0x00, 0x02, 0x13, 0x4B, 0x03 with out_ready=1 -> out 0x41, 0x42 (last on 0x42); frame_done=1, frame_err=0.
- Same frame with trailer 0x04 -> same plaintext; frame_done=1, frame_err=1.
- Counter wrap, key=0xFF, IV=0x00, len=2, cipher 0x7D, 0x52, trailer 0x00 -> out 0x00, 0x00; no error.
- Backpressure: out_ready=0 for 3 cycles mid-payload -> in_ready=0 and out_data held; no byte lost or duplicated once out_ready=1.
- Length error, MAX_LEN=4, in: 0x00, 0x05 -> frame_done=1, frame_err=1, back in HDR; the next frame decodes correctly.
- Zero-length frame (0x00, 0x00, 0x00) -> no out_valid; frame_done=1, frame_err=0. Then assert reset_n=0 mid-payload -> all outputs at reset values and the FSM in HDR.

Source files
------------

// File: rtl/hes_pkg.sv
// Shared types and constants for the HES stream cipher link (encrypt and decrypt sides).
package hes_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {HDR, LEN, PAY, CHK} dec_state_t;

  // AES inverse S-box; the keystream byte for payload index i is INV_SBOX[seed + i].
  localparam byte_t INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/hes_stream_decryptor_if.sv
// Ciphertext-in / plaintext-out ready/valid byte streams of the HES decryptor.
interface hes_stream_decryptor_if;
  import hes_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  in_ready;
  logic  out_valid;
  byte_t out_data;
  logic  out_last;
  logic  out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);

endinterface

// File: rtl/hes_inv_sbox.sv
// Combinational inverse S-box lookup, shared with the transmit side.
module hes_inv_sbox
  import hes_pkg::*;
(
  input  byte_t idx,
  output byte_t data_c
);

  assign data_c = INV_SBOX[idx];

endmodule

// File: rtl/hes_stream_decryptor.sv
// HES receive endpoint: parses IV/length framing, XOR-decrypts the payload with the S-box keystream.
// Build option: define HES_DEC_CHECK_EN to require and verify the XOR checksum trailer.
module hes_stream_decryptor
  import hes_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic  clk,
  input  logic  reset_n,
  input  byte_t key,
  hes_stream_decryptor_if.slave s,
  output logic  frame_done,
  output logic  frame_err
);

  dec_state_t state_q, state_d;
  byte_t      seed_q, seed_d;
  byte_t      cnt_q, cnt_d;
  byte_t      rem_q, rem_d;
  byte_t      out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       rdy_q;
  logic       accept;
  logic       in_ready_c;
  byte_t      ks_c;
  byte_t      pt_c;
`ifdef HES_DEC_CHECK_EN
  byte_t      chk_q, chk_d;
`endif

  hes_inv_sbox u_inv_sbox (.idx(cnt_q), .data_c(ks_c));

  assign pt_c = s.in_data ^ ks_c;

  // Payload stalls only when the single output register is full and not draining.
  assign in_ready_c = rdy_q & ((state_q != PAY) | ~out_valid_q | s.out_ready);
  assign accept     = s.in_valid & in_ready_c;

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q & ~s.out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef HES_DEC_CHECK_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      HDR: if (accept) begin
        seed_d  = key ^ s.in_data;
`ifdef HES_DEC_CHECK_EN
        chk_d   = '0;
`endif
        state_d = LEN;
      end
      LEN: if (accept) begin
        rem_d = s.in_data;
        cnt_d = seed_q;
        if (s.in_data == '0) begin
`ifdef HES_DEC_CHECK_EN
          state_d = CHK;
`else
          state_d = HDR;
          done_d  = 1'b1;
`endif
        end else if (32'(s.in_data) > MAX_LEN) begin
          state_d = HDR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = PAY;
        end
      end
      PAY: if (accept) begin
        out_data_d  = pt_c;
        out_valid_d = 1'b1;
        out_last_d  = (rem_q == 8'd1);
        cnt_d       = cnt_q + 8'd1;
        rem_d       = rem_q - 8'd1;
`ifdef HES_DEC_CHECK_EN
        chk_d       = chk_q ^ pt_c;
        if (rem_q == 8'd1) state_d = CHK;
`else
        if (rem_q == 8'd1) begin
          state_d = HDR;
          done_d  = 1'b1;
        end
`endif
      end
      CHK: begin
`ifdef HES_DEC_CHECK_EN
        if (accept) begin
          done_d  = 1'b1;
          err_d   = (s.in_data != chk_q);
          state_d = HDR;
        end
`else
        state_d = HDR;
`endif
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR;
      seed_q      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
`ifdef HES_DEC_CHECK_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdy_q       <= 1'b1;
`ifdef HES_DEC_CHECK_EN
      chk_q       <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_hes_stream_decryptor.sv
// Scoreboard bench for hes_stream_decryptor; keystream model derived from GF(2^8) arithmetic.
module tb_hes_stream_decryptor;

  localparam int unsigned MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] key;
  logic       frame_done;
  logic       frame_err;

  hes_stream_decryptor_if bus ();

  hes_stream_decryptor #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .s(bus),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [8:0] exp_q [$];
  logic       stat_q [$];
  logic [7:0] inv_tb [256];
  int         rdy_mode = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward AES S-box = affine(GF inverse); the bench stores its inverse mapping.
  task automatic build_inv_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av, inv, sb;
      av  = 8'(a);
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
      sb = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tb[sb] = av;
    end
  endtask

  // Output-ready driver: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.out_ready = ($urandom % 4) != 0;
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard whenever the DUT presents output or status.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
        else check("out_last_data", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_q.pop_front()});
      end
      if (frame_done) begin
        if (stat_q.size() == 0) check("unexpected_done", 1, 0);
        else check("frame_err", 32'(frame_err), 32'(stat_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_gap();
    if (($urandom % 4) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
  endtask

  // Model: plaintext byte i is cipher ^ inverse-sbox[(key ^ iv) + i mod 256].
  task automatic send_frame(input logic [7:0] k, input logic [7:0] iv, input logic [7:0] len, input bit corrupt);
    logic [7:0] seed, pt, sum;
    key  = k;
    seed = k ^ iv;
    sum  = 8'h00;
    idle_gap(); send_byte(iv);
    if (32'(len) > MAX_LEN) begin
      stat_q.push_back(1'b1);
      idle_gap(); send_byte(len);
      return;
    end
`ifndef HES_DEC_CHECK_EN
    if (len == 8'd0) stat_q.push_back(1'b0);
`endif
    idle_gap(); send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      pt  = 8'($urandom);
      sum = sum ^ pt;
      exp_q.push_back({(i == int'(len) - 1), pt});
`ifndef HES_DEC_CHECK_EN
      if (i == int'(len) - 1) stat_q.push_back(1'b0);
`endif
      idle_gap(); send_byte(pt ^ inv_tb[8'(int'(seed) + i)]);
    end
`ifdef HES_DEC_CHECK_EN
    stat_q.push_back(corrupt);
    idle_gap(); send_byte(corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum);
`else
    if (corrupt) idle_gap();
`endif
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && (exp_q.size() != 0 || stat_q.size() != 0); n++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    key           = 8'h00;
    reset_n       = 1'b0;
    build_inv_sbox();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("hdr_in_ready", 32'(bus.in_ready), 1);

    // Basic frame, fixed expected plaintext 0x41 0x42.
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b1, 8'h42});
    stat_q.push_back(1'b0);
    key = 8'h00;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h13); send_byte(8'h4B);
`ifdef HES_DEC_CHECK_EN
    send_byte(8'h03);
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b1, 8'h42});
    stat_q.push_back(1'b1);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h13); send_byte(8'h4B); send_byte(8'h04);
`endif
    wait_drain();

    // Counter wrap 0xFF -> 0x00.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    stat_q.push_back(1'b0);
    key = 8'hFF;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h7D); send_byte(8'h52);
`ifdef HES_DEC_CHECK_EN
    send_byte(8'h00);
`endif
    wait_drain();

    // Length error, then a good frame.
    stat_q.push_back(1'b1);
    key = 8'h00;
    send_byte(8'h00); send_byte(8'h05);
    send_frame(8'h3C, 8'h91, 8'd3, 1'b0);
    // Zero-length frame.
    stat_q.push_back(1'b0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef HES_DEC_CHECK_EN
    send_byte(8'h00);
`endif
    wait_drain();

    // Backpressure: stall output with a payload byte waiting.
    begin
      logic [7:0] seed;
      rdy_mode = 2;
      key  = 8'h5A;
      seed = 8'h5A ^ 8'hC3;
      @(posedge clk); #1;
      send_byte(8'hC3); send_byte(8'd3);
      exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
      stat_q.push_back(1'b0);
      send_byte(8'h11 ^ inv_tb[seed]);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h22 ^ inv_tb[8'(seed + 8'd1)];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 0);
      end
      rdy_mode = 0;
      send_byte(8'h22 ^ inv_tb[8'(seed + 8'd1)]);
      send_byte(8'h33 ^ inv_tb[8'(seed + 8'd2)]);
`ifdef HES_DEC_CHECK_EN
      send_byte(8'h11 ^ 8'h22 ^ 8'h33);
`endif
      wait_drain();
    end

    // Randomized frames with random output backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++)
      send_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, MAX_LEN + 1)), ($urandom % 4) == 0);
    wait_drain();
    rdy_mode = 0;

    // Reset in the middle of a payload.
    key = 8'h77;
    @(posedge clk); #1;
    send_byte(8'h10); send_byte(8'd3);
    exp_q.push_back({1'b0, 8'hAB});
    send_byte(8'hAB ^ inv_tb[8'h77 ^ 8'h10]);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_out_data", 32'(bus.out_data), 0);
    check("mid_rst_out_last", 32'(bus.out_last), 0);
    check("mid_rst_done_err", {30'd0, frame_done, frame_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h21, 8'h43, 8'd2, 1'b0);
    wait_drain();

    check("exp_queue_empty", exp_q.size(), 0);
    check("stat_queue_empty", stat_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
